dff_bank_rr_writer: RTL and testbench
=====================================

Name: dff_bank_rr_writer

Overview:
- Shared bank of NREG D-flip-flop registers, written by NREQ independent requesters.
- Round-robin write arbiter: serializes the requesters into one write port and exposes a combinational read port.
- Sits between request-generating logic and the register storage layer, so that no two writers ever clock the same bank in the same cycle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width of each register.
- NREG, 4, number of registers in the bank (power of 2).
- AW, $clog2(NREG), register address width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester write request, held high until granted.
- wr_addr  input  NREQ*AW  packed addresses; requester i uses slice [i*AW +: AW].
- wr_data  input  NREQ*DW  packed data; requester i uses slice [i*DW +: DW].
- gnt  output  NREQ  registered one-hot grant, single-cycle pulse.
- busy  output  1  high while the FSM is in GRANT.
- rd_addr  input  AW  read address.
- rd_data  output  DW  combinational read, reg[rd_addr].
- wr_cnt  output  8  total committed writes, wraps at 255 -> 0.

Behaviour:
- Reset (asynchronous, active-low, takes effect immediately):
  - all bank registers 0, gnt 0, busy 0, wr_cnt 0, round-robin pointer 0, FSM in IDLE.
  - Reset applies regardless of FSM state.
- FSM states: IDLE, GRANT.
  - IDLE: if req != 0, select the winner and go to GRANT next edge; else stay in IDLE.
  - GRANT: always returns to IDLE next edge. No arbitration happens in GRANT.
- Arbitration (IDLE only): the winner is the first requester with req high, searching i = ptr, ptr+1, ... modulo NREQ.
- Timing:
  - Request sampled in cycle N -> gnt[winner]=1 and busy=1 during cycle N+1.
  - The winner's wr_addr/wr_data are latched at the N->N+1 edge into a pending-write register.
  - The write commits to the bank at the end of cycle N+1.
  - The new value is visible on rd_data from cycle N+2.
  - wr_cnt increments at the same edge as the commit.
- Pointer: set to (winner+1) mod NREQ at the commit edge.
- Requester rule: deassert req in the cycle after gnt (cycle N+2) unless requesting again. A req still high in N+2 is treated as a new request.
- Peak throughput: one write per 2 cycles.
- Data stability: wr_addr/wr_data only need to be stable in the cycle where req is sampled in IDLE. Later changes do not affect the pending write.
- Same address written by successive grants: the last commit wins. No merging.
- rd_addr equal to the address being committed: rd_data shows the old value until the commit edge (no bypass).
- Reset during GRANT: the pending write is discarded, no bank write, wr_cnt is not incremented, gnt drops immediately.
- req bits deasserting in IDLE with no winner: no action.

Decomposition:
- Package dff_bank_pkg holds:
  - the state enum {IDLE, GRANT};
  - the default-parameter localparams;
  - a function rr_pick(req, ptr) returning the winner index and a found flag.
- One sub-module is natural: rr_arbiter_core (combinational round-robin priority search from ptr). The FSM, pending-write registers, bank and counter stay in the top module.

Test Plan:
1. Reset check: hold rst_n=0 for 3 cycles with random req -> gnt=0, busy=0, wr_cnt=0, rd_data=0 for every rd_addr.
2. Single write: req=0010, addr1=2, data1=0xA5 in cycle 0 -> gnt=0010 and busy=1 in cycle 1; rd_addr=2 gives 0xA5 from cycle 2; wr_cnt=1.
3. Round-robin order: req=1111 held, each bit dropped after its own gnt -> grants in cycles 1,3,5,7 in order 0001, 0010, 0100, 1000; wr_cnt=4.
4. Pointer wrap: after a grant to requester 2, assert req=1001 -> first grant 1000, then 0001.
5. Address collision: requester 0 writes 0x11 and requester 1 writes 0x22, both to address 3, both requesting from cycle 0 -> reg[3]=0x11 at cycle 2, 0x22 at cycle 4.
6. Reset mid-grant: pull rst_n low in cycle 1 of scenario 2 -> gnt=0 immediately; after release reg[2]=0, wr_cnt=0, first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/dff_bank_pkg.sv
// Shared types and helpers for the round-robin written register bank.
// Holds the FSM encoding, default sizes and the round-robin search function.
package dff_bank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 8;
   localparam int NREG_DEF = 4;
   localparam int RR_MAX   = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // First set bit of req[0..n-1] searching upward from ptr, wrapping at n.
   function automatic pick_t rr_pick(
      input logic [RR_MAX-1:0] req,
      input logic [2:0]        ptr,
      input int                n
   );
      pick_t      p;
      int         j;
      logic [2:0] jj;
      p = '0;
      for (int k = 0; k < RR_MAX; k++) begin
         j  = (int'(ptr) + k) % n;
         jj = 3'(j);
         if (k < n && !p.found && req[jj]) begin
            p.found = 1'b1;
            p.idx   = jj;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/dff_bank_rr_writer_arb.sv
// Combinational round-robin priority search starting at ptr.
// Requests are widened to the package search width before the pick.
module rr_arbiter_core
   import dff_bank_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic                    found,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int PW = $clog2(NREQ);

   logic [RR_MAX-1:0] req8;
   pick_t             p;

   always_comb begin
      req8           = '0;
      req8[NREQ-1:0] = req;
      p              = rr_pick(req8, 3'(ptr), NREQ);
   end

   assign found = p.found;
   assign idx   = p.idx[PW-1:0];

endmodule

// File: rtl/dff_bank_rr_writer.sv
// Register bank shared by NREQ writers through a round-robin arbiter.
// One write per two cycles; read port is combinational with no bypass.
module dff_bank_rr_writer
   import dff_bank_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int NREG = NREG_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]    gnt,
   output logic               busy,
   input  logic [AW-1:0]      rd_addr,
   output logic [DW-1:0]      rd_data,
   output logic [7:0]         wr_cnt
);

   localparam int PW = $clog2(NREQ);

   state_t         state;
   state_t         state_nx;
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  win;
   logic           found;
   logic [PW-1:0]  pend_idx;
   logic [AW-1:0]  pend_addr;
   logic [DW-1:0]  pend_data;
   logic [DW-1:0]  bank [NREG];

   rr_arbiter_core #(
      .NREQ (NREQ)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .found (found),
      .idx   (win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (found) state_nx = GRANT;
         GRANT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Grant is decoded from registered state only, so it never glitches.
   always_comb begin
      busy = (state == GRANT);
      gnt  = '0;
      if (busy) gnt[pend_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_idx  <= '0;
         pend_addr <= '0;
         pend_data <= '0;
         ptr       <= '0;
         wr_cnt    <= '0;
         for (int i = 0; i < NREG; i++) bank[i] <= '0;
      end else begin
         if (state == IDLE && found) begin
            pend_idx  <= win;
            pend_addr <= wr_addr[win*AW +: AW];
            pend_data <= wr_data[win*DW +: DW];
         end
         if (state == GRANT) begin
            bank[pend_addr] <= pend_data;
            wr_cnt          <= wr_cnt + 8'd1;
            ptr <= (pend_idx == PW'(NREQ-1)) ? '0 : pend_idx + 1'b1;
         end
      end
   end

   assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_dff_bank_rr_writer.sv
// Scoreboard bench for the round-robin bank writer.
// Expected grants are queued as requests are raised, checked as grants appear.
module tb_dff_bank_rr_writer;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int NREG = 4;
   localparam int AW   = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] wr_addr;
   logic [NREQ*DW-1:0] wr_data;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic [AW-1:0]      rd_addr;
   logic [DW-1:0]      rd_data;
   logic [7:0]         wr_cnt;

   typedef struct {
      logic [NREQ-1:0] g;
      logic [AW-1:0]   a;
      logic [DW-1:0]   d;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mdl [NREG];
   int            checks;
   int            failures;

   dff_bank_rr_writer #(
      .NREQ (NREQ),
      .DW   (DW),
      .NREG (NREG)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .gnt     (gnt),
      .busy    (busy),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_cnt  (wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic post(input int i, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      exp_t e;
      wr_addr[i*AW +: AW] = a;
      wr_data[i*DW +: DW] = d;
      e.g = NREQ'(1) << i;
      e.a = a;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
   endtask

   task automatic drain(input int n, input int first);
      int   got;
      int   cyc;
      int   last;
      int   want;
      exp_t e;
      got = 0;
      cyc = 0;
      last = 0;
      while (got < n && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (gnt != '0) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_empty got gnt=%b", gnt);
               e.g = '0; e.a = '0; e.d = '0;
            end else begin
               e = sb.pop_front();
            end
            if (gnt !== e.g) begin
               failures++;
               $display("FAIL gnt got=%b exp=%b", gnt, e.g);
            end
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL busy_grant got=%b exp=1", busy);
            end
            want = (got == 0) ? first : last + 2;
            checks++;
            if (cyc != want) begin
               failures++;
               $display("FAIL gnt_cycle got=%0d exp=%0d", cyc, want);
            end
            last = cyc;
            got++;
            for (int i = 0; i < NREQ; i++)
               if (gnt[i]) wr_data[i*DW +: DW] = ~e.d;
            req     = req & ~gnt;
            rd_addr = e.a;
            #1;
            checks++;
            if (rd_data !== mdl[e.a]) begin
               failures++;
               $display("FAIL no_bypass got=%h exp=%h", rd_data, mdl[e.a]);
            end
            mdl[e.a] = e.d;
            @(negedge clk);
            cyc++;
            checks++;
            if (rd_data !== e.d) begin
               failures++;
               $display("FAIL rd_commit got=%h exp=%h", rd_data, e.d);
            end
            checks++;
            if (busy !== 1'b0) begin
               failures++;
               $display("FAIL busy_idle got=%b exp=0", busy);
            end
         end
      end
      checks++;
      if (got < n) begin
         failures++;
         $display("FAIL grant_timeout got=%0d exp=%0d", got, n);
      end
   endtask

   task automatic check_cnt(input logic [7:0] exp);
      checks++;
      if (wr_cnt !== exp) begin
         failures++;
         $display("FAIL wr_cnt got=%0d exp=%0d", wr_cnt, exp);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      rd_addr = '0;
      wr_addr = NREQ*AW'($urandom);
      wr_data = NREQ*DW'($urandom);
      for (int c = 0; c < 3; c++) begin
         req = NREQ'($urandom);
         @(negedge clk);
         checks++;
         if (gnt !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt got=%b/%b exp=0/0", gnt, busy);
         end
      end
      check_cnt(8'd0);
      for (int i = 0; i < NREG; i++) begin
         rd_addr = AW'(i);
         #1;
         checks++;
         if (rd_data !== '0) begin
            failures++;
            $display("FAIL reset_rd a=%0d got=%h exp=0", i, rd_data);
         end
      end
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
   endtask

   task automatic test_single();
      post(1, 2'd2, 8'hA5);
      req = 4'b0010;
      drain(1, 1);
      check_cnt(8'd1);
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NREQ; i++)
         post(i, AW'(i), DW'(8'h10 + i));
      req = 4'b1111;
      drain(4, 1);
      check_cnt(8'd4);
   endtask

   task automatic test_ptr_wrap();
      post(2, 2'd1, 8'h33);
      req = 4'b0100;
      drain(1, 1);
      post(3, 2'd0, 8'h44);
      post(0, 2'd3, 8'h55);
      req = 4'b1001;
      drain(2, 1);
      check_cnt(8'd7);
   endtask

   task automatic test_collision();
      do_reset();
      post(0, 2'd3, 8'h11);
      post(1, 2'd3, 8'h22);
      req = 4'b0011;
      drain(2, 1);
      check_cnt(8'd2);
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      wr_addr[1*AW +: AW] = 2'd2;
      wr_data[1*DW +: DW] = 8'hA5;
      req = 4'b0010;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL mid_gnt got=%b exp=0010", gnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== '0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_drop got=%b/%b exp=0/0", gnt, busy);
      end
      req = '0;
      @(negedge clk);
      rst_n   = 1'b1;
      rd_addr = 2'd2;
      @(negedge clk);
      checks++;
      if (rd_data !== '0) begin
         failures++;
         $display("FAIL mid_bank got=%h exp=0", rd_data);
      end
      check_cnt(8'd0);
      post(1, 2'd1, 8'h66);
      post(3, 2'd0, 8'h77);
      req = 4'b1010;
      drain(2, 1);
      check_cnt(8'd2);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      req      = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr  = '0;
      rst_n    = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_ptr_wrap();
      test_collision();
      test_reset_mid_grant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
